// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock synchronous FIFO with generic width and depth.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush_i           discard all stored entries (data_o holds)
//   wr_en_i, data_i   push request and data
//   rd_en_i, data_o   pop request and registered pop data (1-edge latency)
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o
//                     occupancy and its decoded flags, all from the count register
//   overflow_o, underflow_o, err_clr_i
//                     sticky error flags and their clear (a same-edge set wins)
module sync_fifo_param #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 4,
  parameter  int AE_LEVEL = 2,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o,
  input  logic              err_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop_ok, push_ok;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign pop_ok  = rd_en_i && (count != '0);
  assign push_ok = wr_en_i && ((count != DEPTH_C) || pop_ok);

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_o      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (err_clr_i) begin
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
        data_o <= mem[rd_ptr];
      end
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      // Set has priority over clear.
      overflow_o  <= (overflow_o  & ~err_clr_i) | (wr_en_i & ~push_ok);
      underflow_o <= (underflow_o & ~err_clr_i) | (rd_en_i & ~pop_ok);
    end
  end

  // Storage is not reset; on a full push+pop the read above sees the old word.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_ok) mem[wr_ptr] <= data_i;
  end

  assign count_o        = count;
  assign full_o         = (count == DEPTH_C);
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= AF_C);
  assign almost_empty_o = (count <= AE_C);

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default DEPTH=16; DUT B: DEPTH=5 for pointer wrap.
  logic       a_fl = 0, a_wr = 0, a_rd = 0, a_clr = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_cnt;
  logic       b_fl = 0, b_wr = 0, b_rd = 0, b_clr = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_cnt;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .flush_i(a_fl), .wr_en_i(a_wr), .data_i(a_din),
    .rd_en_i(a_rd), .data_o(a_dout), .full_o(a_full), .empty_o(a_empty),
    .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_cnt),
    .overflow_o(a_ovf), .underflow_o(a_udf), .err_clr_i(a_clr));

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst), .flush_i(b_fl), .wr_en_i(b_wr), .data_i(b_din),
    .rd_en_i(b_rd), .data_o(b_dout), .full_o(b_full), .empty_o(b_empty),
    .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_cnt),
    .overflow_o(b_ovf), .underflow_o(b_udf), .err_clr_i(b_clr));

  // Reference model: queues of stored words plus last popped word and sticky bits.
  logic [7:0] qa[$], qb[$];
  logic [7:0] md[2];
  bit         mo[2], mu[2];
  int         dep[2] = '{16, 5};
  int         afl[2] = '{12, 4};
  int         ael[2] = '{2, 1};
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int d, input bit r, fl, wr, rd, clr, input logic [7:0] din);
    int  sz;
    bit  pop, push;
    sz = (d == 0) ? qa.size() : qb.size();
    if (r) begin
      if (d == 0) qa.delete(); else qb.delete();
      md[d] = 0; mo[d] = 0; mu[d] = 0;
    end else if (fl) begin
      if (d == 0) qa.delete(); else qb.delete();
      if (clr) begin mo[d] = 0; mu[d] = 0; end
    end else begin
      pop  = rd && sz > 0;
      push = wr && (sz < dep[d] || pop);
      if (pop)  md[d] = (d == 0) ? qa.pop_front() : qb.pop_front();
      if (push) begin if (d == 0) qa.push_back(din); else qb.push_back(din); end
      if (clr) begin mo[d] = 0; mu[d] = 0; end
      if (wr && !push) mo[d] = 1;
      if (rd && sz == 0) mu[d] = 1;
    end
  endtask

  task automatic check_all();
    int s;
    s = qa.size();
    chk("a_data", a_dout, md[0]);   chk("a_count", a_cnt, s);
    chk("a_full", a_full, s == 16); chk("a_empty", a_empty, s == 0);
    chk("a_af", a_af, s >= afl[0]); chk("a_ae", a_ae, s <= ael[0]);
    chk("a_ovf", a_ovf, mo[0]);     chk("a_udf", a_udf, mu[0]);
    s = qb.size();
    chk("b_data", b_dout, md[1]);   chk("b_count", b_cnt, s);
    chk("b_full", b_full, s == 5);  chk("b_empty", b_empty, s == 0);
    chk("b_af", b_af, s >= afl[1]); chk("b_ae", b_ae, s <= ael[1]);
    chk("b_ovf", b_ovf, mo[1]);     chk("b_udf", b_udf, mu[1]);
  endtask

  // One clock edge with both DUTs' inputs given; outputs checked 1 time unit later.
  task automatic cyc(input bit r,
                     input bit afl_, awr, ard, aclr, input logic [7:0] ad,
                     input bit bfl_, bwr, brd, bclr, input logic [7:0] bd);
    rst = r;
    a_fl = afl_; a_wr = awr; a_rd = ard; a_clr = aclr; a_din = ad;
    b_fl = bfl_; b_wr = bwr; b_rd = brd; b_clr = bclr; b_din = bd;
    @(posedge clk); #1;
    model(0, r, afl_, awr, ard, aclr, ad);
    model(1, r, bfl_, bwr, brd, bclr, bd);
    check_all();
  endtask

  task automatic a_step(input bit fl, wr, rd, clr, input logic [7:0] d);
    cyc(0, fl, wr, rd, clr, d, 0, 0, 0, 0, 8'h0);
  endtask

  task automatic b_step(input bit wr, rd, input logic [7:0] d);
    cyc(0, 0, 0, 0, 0, 8'h0, 0, wr, rd, 0, d);
  endtask

  initial begin
    // Reset for two cycles.
    cyc(1, 0, 1, 1, 1, 8'hFF, 0, 1, 1, 1, 8'hFF);
    cyc(1, 0, 0, 0, 0, 8'h0, 0, 0, 0, 0, 8'h0);
    chk("rst_count", a_cnt, 0); chk("rst_data", a_dout, 0);
    chk("rst_empty", a_empty, 1); chk("rst_ae", a_ae, 1);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      a_step(0, 1, 0, 0, 8'(i));
      chk("fill_count", a_cnt, i);
      chk("fill_af", a_af, i >= 12);
    end
    chk("fill_full", a_full, 1); chk("fill_ovf", a_ovf, 0);

    // Overflow, then drain.
    a_step(0, 1, 0, 0, 8'hAA);
    chk("ovf_set", a_ovf, 1); chk("ovf_count", a_cnt, 16);
    for (int i = 1; i <= 16; i++) begin
      a_step(0, 0, 1, 0, 8'h0);
      chk("drain_data", a_dout, i);
      chk("drain_ae", a_ae, (16 - i) <= 2);
    end
    chk("drain_empty", a_empty, 1); chk("ovf_sticky", a_ovf, 1);

    // Underflow and push+pop on empty.
    a_step(0, 0, 1, 0, 8'h0);
    chk("udf_set", a_udf, 1); chk("udf_data", a_dout, 8'h10);
    a_step(0, 1, 1, 0, 8'h55);
    chk("pp_empty_count", a_cnt, 1); chk("pp_empty_data", a_dout, 8'h10);
    a_step(0, 0, 1, 0, 8'h0);
    chk("pop_55", a_dout, 8'h55);

    // Clear errors, then full push+pop.
    a_step(0, 0, 0, 1, 8'h0);
    chk("clr_ovf", a_ovf, 0); chk("clr_udf", a_udf, 0);
    for (int i = 0; i < 16; i++) a_step(0, 1, 0, 0, 8'(8'h20 + i));
    a_step(0, 1, 1, 0, 8'h30);
    chk("ppf_data", a_dout, 8'h20); chk("ppf_count", a_cnt, 16);
    chk("ppf_full", a_full, 1);     chk("ppf_ovf", a_ovf, 0);
    for (int i = 1; i <= 16; i++) begin
      a_step(0, 0, 1, 0, 8'h0);
      chk("ppf_drain", a_dout, 8'h20 + i);
    end

    // Wrap on DEPTH=5.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        b_step(1, 0, 8'(r * 16 + i + 1));
        chk("wrap_cnt_max", b_cnt <= 5, 1);
      end
      for (int i = 0; i < 5; i++) begin
        b_step(0, 1, 8'h0);
        chk("wrap_data", b_dout, r * 16 + i + 1);
      end
    end

    // Flush and clear.
    for (int i = 0; i < 7; i++) a_step(0, 1, 0, 0, 8'(8'h60 + i));
    a_step(1, 1, 0, 0, 8'h99);
    chk("flush_count", a_cnt, 0); chk("flush_empty", a_empty, 1);
    chk("flush_ovf", a_ovf, 0);   chk("flush_udf", a_udf, 0);
    chk("flush_data", a_dout, 8'h30);
    a_step(0, 0, 1, 1, 8'h0);
    chk("clr_set_wins", a_udf, 1);
    a_step(0, 0, 0, 1, 8'h0);
    chk("clr_alone", a_udf, 0);
    for (int i = 0; i < 3; i++) a_step(0, 1, 0, 0, 8'(8'h70 + i));
    cyc(1, 0, 1, 0, 0, 8'h0, 0, 0, 0, 0, 8'h0);
    chk("rst_mid", a_cnt, 0);

    // Random traffic on both FIFOs; flush and clear are rare.
    for (int n = 0; n < 600; n++) begin
      cyc(0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
          $urandom_range(0, 20) == 0, 8'($urandom),
          $urandom_range(0, 40) == 0, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50,
          $urandom_range(0, 20) == 0, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
